axil_reg_slave: RTL and testbench

- AXI4-Lite responder with a four-word register bank.
- Sits on one master-side port (m1 or m2) of the two-way interconnect and terminates write and read transactions from it.
- BASE_ADDR selects the window, so the same block serves slave 1 (0x00) and slave 2 (0x10).
- Exposes control and data registers to downstream fabric logic.

---
 rtl/axil_pkg.sv | 30 +++
 rtl/axil_strb_merge.sv | 23 ++
 rtl/axil_reg_slave.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared response codes, register offsets and FSM state types for axil_reg_slave.
package axil_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'd0;
  localparam logic [2:0] RESP_SLVERR = 3'd2;

  localparam logic [3:0] OFS_CTRL  = 4'h0;
  localparam logic [3:0] OFS_DATA  = 4'h4;
  localparam logic [3:0] OFS_WRCNT = 4'h8;
  localparam logic [3:0] OFS_ID    = 4'hC;

  typedef enum logic [2:0] {
    W_IDLE      = 3'd0,
    W_HAVE_ADDR = 3'd1,
    W_HAVE_DATA = 3'd2,
    W_COMMIT    = 3'd3,
    W_RESP      = 3'd4
  } w_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Only CTRL and DATA accept bus writes; WR_COUNT and ID are read-only.
  function automatic logic ofs_writable(input logic [3:0] ofs);
    return (ofs == OFS_CTRL) || (ofs == OFS_DATA);
  endfunction

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-strobe merge: each strobe bit selects the new byte over the old one.
module axil_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  // Per-byte select between stored and incoming data.
  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (strb_i[i]) begin
        merged_o[8*i +: 8] = wdata_i[8*i +: 8];
      end else begin
        merged_o[8*i +: 8] = old_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder with CTRL/DATA/WR_COUNT/ID registers at BASE_ADDR..BASE_ADDR+15.
// Optional interrupt output enabled by defining AXIL_REG_SLAVE_IRQ_EN.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h00,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5A5_0001
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  output logic [DATA_WIDTH-1:0]   ctrl_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    data_wr_o
`ifdef AXIL_REG_SLAVE_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  localparam int SW = DATA_WIDTH/8;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d, data_q, data_d, wrcnt_q, wrcnt_d;
  logic                  data_wr_q, data_wr_d;
`ifdef AXIL_REG_SLAVE_IRQ_EN
  logic                  irq_q, irq_d;
`endif

  logic                  aw_hs_s, w_hs_s, ar_hs_s;
  logic [ADDR_WIDTH-1:0] wofs_s, rofs_s;
  logic                  w_hit_s, w_ok_s, w_is_data_s, r_hit_s;
  logic [DATA_WIDTH-1:0] merge_old_s, merged_s, rd_val_s;
  logic [RESP_WIDTH-1:0] rd_resp_s;

  assign aw_hs_s = s0_axi_awvalid & awready_q;
  assign w_hs_s  = s0_axi_wvalid & wready_q;
  assign ar_hs_s = s0_axi_arvalid & arready_q;

  // Underflow below BASE_ADDR wraps to a large offset and so misses the window.
  assign wofs_s      = awaddr_q - BASE_ADDR;
  assign w_hit_s     = (wofs_s < ADDR_WIDTH'(16)) && (awaddr_q[1:0] == 2'b00);
  assign w_ok_s      = w_hit_s && ofs_writable(wofs_s[3:0]);
  assign w_is_data_s = (wofs_s[3:0] == OFS_DATA);
  assign merge_old_s = w_is_data_s ? data_q : ctrl_q;

  assign rofs_s  = s0_axi_araddr - BASE_ADDR;
  assign r_hit_s = (rofs_s < ADDR_WIDTH'(16)) && (s0_axi_araddr[1:0] == 2'b00);

  axil_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_i    (merge_old_s),
    .wdata_i  (wdata_q),
    .strb_i   (wstrb_q),
    .merged_o (merged_s)
  );

  // Write channel next-state logic.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) w_state_d = W_COMMIT;
        else if (aw_hs_s)      w_state_d = W_HAVE_ADDR;
        else if (w_hs_s)       w_state_d = W_HAVE_DATA;
        else                   w_state_d = W_IDLE;
      end
      W_HAVE_ADDR: begin
        if (w_hs_s) w_state_d = W_COMMIT;
        else        w_state_d = W_HAVE_ADDR;
      end
      W_HAVE_DATA: begin
        if (aw_hs_s) w_state_d = W_COMMIT;
        else         w_state_d = W_HAVE_DATA;
      end
      W_COMMIT: w_state_d = W_RESP;
      W_RESP: begin
        if (s0_axi_bready) w_state_d = W_IDLE;
        else               w_state_d = W_RESP;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel next-state logic.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) r_state_d = R_DATA;
        else         r_state_d = R_IDLE;
      end
      R_DATA: begin
        if (s0_axi_rready) r_state_d = R_IDLE;
        else               r_state_d = R_DATA;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Handshake outputs follow the next state so they are registered, not combinational.
  always_comb begin
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
    bvalid_d  = (w_state_d == W_RESP);
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    if (w_state_q == W_COMMIT) begin
      bresp_d = w_ok_s ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
    end else begin
      bresp_d = bresp_q;
    end
  end

  // Read data mux sampled on the AR handshake.
  always_comb begin
    rd_val_s  = {DATA_WIDTH{1'b0}};
    rd_resp_s = RESP_WIDTH'(RESP_SLVERR);
    if (r_hit_s) begin
      rd_resp_s = RESP_WIDTH'(RESP_OKAY);
      case (rofs_s[3:0])
        OFS_CTRL:  rd_val_s = ctrl_q;
        OFS_DATA:  rd_val_s = data_q;
        OFS_WRCNT: rd_val_s = wrcnt_q;
        OFS_ID:    rd_val_s = ID_VALUE;
        default:   rd_val_s = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      rd_val_s  = {DATA_WIDTH{1'b0}};
      rd_resp_s = RESP_WIDTH'(RESP_SLVERR);
    end
    rdata_d = ar_hs_s ? rd_val_s : rdata_q;
    rresp_d = ar_hs_s ? rd_resp_s : rresp_q;
  end

  // Capture of write address/data and the single-cycle register commit.
  always_comb begin
    awaddr_d  = aw_hs_s ? s0_axi_awaddr : awaddr_q;
    wdata_d   = w_hs_s ? s0_axi_wdata : wdata_q;
    wstrb_d   = w_hs_s ? s0_axi_wstrb[SW-1:0] : wstrb_q;
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    wrcnt_d   = wrcnt_q;
    data_wr_d = 1'b0;
`ifdef AXIL_REG_SLAVE_IRQ_EN
    irq_d     = irq_q;
`endif
    if ((w_state_q == W_COMMIT) && w_ok_s) begin
      wrcnt_d = wrcnt_q + DATA_WIDTH'(1);
      if (w_is_data_s) begin
        data_d    = merged_s;
        data_wr_d = 1'b1;
      end else begin
`ifdef AXIL_REG_SLAVE_IRQ_EN
        // Bit 31 is a write-one-to-clear command for irq_o and never stored.
        ctrl_d = {1'b0, merged_s[DATA_WIDTH-2:0]};
`else
        ctrl_d = merged_s;
`endif
      end
`ifdef AXIL_REG_SLAVE_IRQ_EN
      if (!w_is_data_s && wstrb_q[SW-1] && wdata_q[DATA_WIDTH-1]) irq_d = 1'b0;
      else if (w_is_data_s && ctrl_q[0])                          irq_d = 1'b1;
      else                                                        irq_d = irq_q;
`endif
    end else begin
      wrcnt_d = wrcnt_q;
    end
  end

  // FSM state registers.
  always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
    if (s0_axi_areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Output, capture and register-bank flops.
  always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
    if (s0_axi_areset) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      arready_q <= 1'b1;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= {RESP_WIDTH{1'b0}};
      rresp_q   <= {RESP_WIDTH{1'b0}};
      rdata_q   <= {DATA_WIDTH{1'b0}};
      awaddr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      wstrb_q   <= {SW{1'b0}};
      ctrl_q    <= {DATA_WIDTH{1'b0}};
      data_q    <= {DATA_WIDTH{1'b0}};
      wrcnt_q   <= {DATA_WIDTH{1'b0}};
      data_wr_q <= 1'b0;
`ifdef AXIL_REG_SLAVE_IRQ_EN
      irq_q     <= 1'b0;
`endif
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      wrcnt_q   <= wrcnt_d;
      data_wr_q <= data_wr_d;
`ifdef AXIL_REG_SLAVE_IRQ_EN
      irq_q     <= irq_d;
`endif
    end
  end

  assign s0_axi_awready = awready_q;
  assign s0_axi_wready  = wready_q;
  assign s0_axi_bresp   = bresp_q;
  assign s0_axi_bvalid  = bvalid_q;
  assign s0_axi_arready = arready_q;
  assign s0_axi_rdata   = rdata_q;
  assign s0_axi_rresp   = rresp_q;
  assign s0_axi_rvalid  = rvalid_q;
  assign ctrl_o         = ctrl_q;
  assign data_o         = data_q;
  assign data_wr_o      = data_wr_q;
`ifdef AXIL_REG_SLAVE_IRQ_EN
  assign irq_o          = irq_q;
`endif

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: instance 0 at BASE_ADDR 0x00, instance 1 at 0x10.
module tb_axil_reg_slave;

  logic        clk, rst;
  logic [7:0]  awaddr [2];
  logic        awvalid[2], awready[2];
  logic [31:0] wdata  [2];
  logic [4:0]  wstrb  [2];
  logic        wvalid [2], wready[2];
  logic [2:0]  bresp  [2];
  logic        bvalid [2], bready[2];
  logic [7:0]  araddr [2];
  logic        arvalid[2], arready[2];
  logic [31:0] rdata  [2];
  logic [2:0]  rresp  [2];
  logic        rvalid [2], rready[2];
  logic [31:0] ctrl   [2], data[2];
  logic        data_wr[2];
`ifdef AXIL_REG_SLAVE_IRQ_EN
  logic        irq    [2];
`endif

  int tests = 0;
  int fails = 0;
  int pulses0 = 0;

  axil_reg_slave #(.BASE_ADDR(8'h00)) u0 (
    .s0_axi_aclk(clk), .s0_axi_areset(rst),
    .s0_axi_awaddr(awaddr[0]), .s0_axi_awvalid(awvalid[0]), .s0_axi_awready(awready[0]),
    .s0_axi_wdata(wdata[0]), .s0_axi_wstrb(wstrb[0]), .s0_axi_wvalid(wvalid[0]), .s0_axi_wready(wready[0]),
    .s0_axi_bresp(bresp[0]), .s0_axi_bvalid(bvalid[0]), .s0_axi_bready(bready[0]),
    .s0_axi_araddr(araddr[0]), .s0_axi_arvalid(arvalid[0]), .s0_axi_arready(arready[0]),
    .s0_axi_rdata(rdata[0]), .s0_axi_rresp(rresp[0]), .s0_axi_rvalid(rvalid[0]), .s0_axi_rready(rready[0]),
    .ctrl_o(ctrl[0]), .data_o(data[0]), .data_wr_o(data_wr[0])
`ifdef AXIL_REG_SLAVE_IRQ_EN
    , .irq_o(irq[0])
`endif
  );

  axil_reg_slave #(.BASE_ADDR(8'h10)) u1 (
    .s0_axi_aclk(clk), .s0_axi_areset(rst),
    .s0_axi_awaddr(awaddr[1]), .s0_axi_awvalid(awvalid[1]), .s0_axi_awready(awready[1]),
    .s0_axi_wdata(wdata[1]), .s0_axi_wstrb(wstrb[1]), .s0_axi_wvalid(wvalid[1]), .s0_axi_wready(wready[1]),
    .s0_axi_bresp(bresp[1]), .s0_axi_bvalid(bvalid[1]), .s0_axi_bready(bready[1]),
    .s0_axi_araddr(araddr[1]), .s0_axi_arvalid(arvalid[1]), .s0_axi_arready(arready[1]),
    .s0_axi_rdata(rdata[1]), .s0_axi_rresp(rresp[1]), .s0_axi_rvalid(rvalid[1]), .s0_axi_rready(rready[1]),
    .ctrl_o(ctrl[1]), .data_o(data[1]), .data_wr_o(data_wr[1])
`ifdef AXIL_REG_SLAVE_IRQ_EN
    , .irq_o(irq[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts data_wr_o pulses of instance 0, one per high cycle.
  always @(negedge clk) begin
    if (data_wr[0]) pulses0 <= pulses0 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full write; W leads AW by w_lead cycles, bready held low for bhold cycles.
  task automatic do_write(input int s, input logic [7:0] a, input logic [31:0] d,
                          input logic [4:0] st, input int w_lead, input int bhold,
                          output logic [2:0] resp, output int lat);
    bit aw_hs, w_hs, a_now, w_now, stable;
    int cyc, k;
    aw_hs = 1'b0; w_hs = 1'b0; cyc = 0;
    wdata[s] = d; wstrb[s] = st; wvalid[s] = 1'b1;
    while (!(aw_hs && w_hs) && cyc < 50) begin
      if (cyc == w_lead) begin awaddr[s] = a; awvalid[s] = 1'b1; end
      a_now = awvalid[s] && awready[s];
      w_now = wvalid[s] && wready[s];
      @(negedge clk); cyc++;
      if (a_now) begin awvalid[s] = 1'b0; aw_hs = 1'b1; end
      if (w_now) begin wvalid[s] = 1'b0; w_hs = 1'b1; end
    end
    chk("wr_handshake_done", {31'd0, aw_hs && w_hs}, 32'd1);
    k = 0;
    while (!bvalid[s] && k < 20) begin @(negedge clk); k++; end
    lat = k + 1;
    resp = bresp[s];
    stable = 1'b1;
    for (int i = 0; i < bhold; i++) begin
      @(negedge clk);
      if (bvalid[s] !== 1'b1 || bresp[s] !== resp || awready[s] !== 1'b0 || wready[s] !== 1'b0)
        stable = 1'b0;
    end
    if (bhold > 0) chk("b_hold_stable", {31'd0, stable}, 32'd1);
    bready[s] = 1'b1;
    @(negedge clk);
    bready[s] = 1'b0;
    chk("b_release", {29'd0, bvalid[s], awready[s], wready[s]}, 32'b011);
  endtask

  // Full read; rready held low for rhold cycles.
  task automatic do_read(input int s, input logic [7:0] a, input int rhold,
                         output logic [31:0] d, output logic [2:0] resp, output int lat);
    bit stable;
    int k;
    araddr[s] = a; arvalid[s] = 1'b1; k = 0;
    while (!arready[s] && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    arvalid[s] = 1'b0;
    k = 0;
    while (!rvalid[s] && k < 20) begin @(negedge clk); k++; end
    lat = k + 1;
    d = rdata[s];
    resp = rresp[s];
    stable = 1'b1;
    for (int i = 0; i < rhold; i++) begin
      @(negedge clk);
      if (rvalid[s] !== 1'b1 || rdata[s] !== d || rresp[s] !== resp || arready[s] !== 1'b0)
        stable = 1'b0;
    end
    if (rhold > 0) chk("r_hold_stable", {31'd0, stable}, 32'd1);
    rready[s] = 1'b1;
    @(negedge clk);
    rready[s] = 1'b0;
    chk("r_release", {30'd0, rvalid[s], arready[s]}, 32'b01);
  endtask

  initial begin
    logic [2:0]  resp;
    logic [31:0] rd;
    int          lat;
    int          p_before;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = 8'h00; awvalid[i] = 1'b0; wdata[i] = 32'h0; wstrb[i] = 5'h0;
      wvalid[i] = 1'b0; bready[i] = 1'b0; araddr[i] = 8'h00; arvalid[i] = 1'b0; rready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_handshakes", {26'd0, awready[0], wready[0], arready[0], bvalid[0], rvalid[0], data_wr[0]}, 32'b111000);
    chk("reset_ctrl", ctrl[0], 32'h0);
    chk("reset_data", data[0], 32'h0);
    chk("reset_rdata_resp", {rdata[0][28:0], bresp[0]} | {29'd0, rresp[0]}, 32'h0);
    @(negedge clk);

    // Simultaneous AW/W write to CTRL
    do_write(0, 8'h00, 32'h1234_5678, 5'h0F, 0, 0, resp, lat);
    chk("w_ctrl_bresp", {29'd0, resp}, 32'd0);
    chk("w_ctrl_latency", lat, 32'd2);
    chk("ctrl_o_after_write", ctrl[0], 32'h1234_5678);
    do_read(0, 8'h00, 0, rd, resp, lat);
    chk("r_ctrl_data", rd, 32'h1234_5678);
    chk("r_ctrl_resp", {29'd0, resp}, 32'd0);
    chk("r_latency", lat, 32'd1);
    do_read(0, 8'h08, 0, rd, resp, lat);
    chk("wrcnt_1", rd, 32'd1);

    // W leads AW by three cycles, lower two strobes only
    p_before = pulses0;
    do_write(0, 8'h04, 32'hDEAD_BEEF, 5'h03, 3, 0, resp, lat);
    chk("w_data_bresp", {29'd0, resp}, 32'd0);
    chk("w_data_latency", lat, 32'd2);
    chk("data_o_partial", data[0], 32'h0000_BEEF);
    chk("data_wr_pulse_once", pulses0 - p_before, 32'd1);
    do_read(0, 8'h04, 0, rd, resp, lat);
    chk("r_data", rd, 32'h0000_BEEF);

    // Only the ignored strobe MSB set: OKAY, no data change, still counted
    do_write(0, 8'h00, 32'hFFFF_FFFF, 5'h10, 0, 0, resp, lat);
    chk("w_nostrb_bresp", {29'd0, resp}, 32'd0);
    chk("ctrl_nostrb", ctrl[0], 32'h1234_5678);
    do_write(0, 8'h00, 32'hAABB_CCDD, 5'h04, 1, 0, resp, lat);
    chk("ctrl_byte2", ctrl[0], 32'h12BB_5678);
    do_read(0, 8'h08, 0, rd, resp, lat);
    chk("wrcnt_4", rd, 32'd4);

    // Decode errors on instance 0
    do_write(0, 8'h02, 32'h1, 5'h0F, 0, 0, resp, lat);
    chk("w_misaligned", {29'd0, resp}, 32'd2);
    do_write(0, 8'h08, 32'h1, 5'h0F, 0, 0, resp, lat);
    chk("w_wrcnt_ro", {29'd0, resp}, 32'd2);
    do_write(0, 8'h0C, 32'h1, 5'h0F, 0, 0, resp, lat);
    chk("w_id_ro", {29'd0, resp}, 32'd2);
    do_write(0, 8'h20, 32'h1, 5'h0F, 0, 0, resp, lat);
    chk("w_outside", {29'd0, resp}, 32'd2);
    chk("ctrl_after_errors", ctrl[0], 32'h12BB_5678);
    do_read(0, 8'h08, 0, rd, resp, lat);
    chk("wrcnt_after_errors", rd, 32'd4);
    do_read(0, 8'h0C, 0, rd, resp, lat);
    chk("r_id", rd, 32'hA5A5_0001);
    do_read(0, 8'h10, 0, rd, resp, lat);
    chk("r_outside_resp", {29'd0, resp}, 32'd2);
    chk("r_outside_data", rd, 32'h0);

    // Instance at BASE_ADDR 0x10
    do_write(1, 8'h04, 32'h1, 5'h0F, 0, 0, resp, lat);
    chk("b1_w_below", {29'd0, resp}, 32'd2);
    do_read(1, 8'h13, 0, rd, resp, lat);
    chk("b1_r13_resp", {29'd0, resp}, 32'd2);
    chk("b1_r13_data", rd, 32'h0);
    do_read(1, 8'h1C, 0, rd, resp, lat);
    chk("b1_r1c_resp", {29'd0, resp}, 32'd0);
    chk("b1_r1c_data", rd, 32'hA5A5_0001);
    do_write(1, 8'h14, 32'h55, 5'h0F, 0, 0, resp, lat);
    chk("b1_data_o", data[1], 32'h0000_0055);

    // Back-pressure on B and R
    do_write(0, 8'h04, 32'h1122_3344, 5'h0F, 0, 5, resp, lat);
    chk("hold_w_bresp", {29'd0, resp}, 32'd0);
    do_read(0, 8'h04, 5, rd, resp, lat);
    chk("hold_r_data", rd, 32'h1122_3344);

    // Reset while waiting for W data
    awaddr[0] = 8'h00; awvalid[0] = 1'b1;
    @(negedge clk);
    awvalid[0] = 1'b0;
    chk("have_addr_awready", {31'd0, awready[0]}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_handshakes", {26'd0, awready[0], wready[0], arready[0], bvalid[0], rvalid[0], data_wr[0]}, 32'b111000);
    chk("midrst_ctrl", ctrl[0], 32'h0);
    chk("midrst_data", data[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(0, 8'h08, 0, rd, resp, lat);
    chk("midrst_wrcnt", rd, 32'd0);
    do_write(0, 8'h04, 32'hCAFE_F00D, 5'h0F, 0, 0, resp, lat);
    chk("post_rst_bresp", {29'd0, resp}, 32'd0);
    chk("post_rst_data", data[0], 32'hCAFE_F00D);
    do_read(0, 8'h08, 0, rd, resp, lat);
    chk("post_rst_wrcnt", rd, 32'd1);

`ifdef AXIL_REG_SLAVE_IRQ_EN
    do_write(0, 8'h00, 32'h0000_0001, 5'h0F, 0, 0, resp, lat);
    chk("irq_idle", {31'd0, irq[0]}, 32'd0);
    do_write(0, 8'h04, 32'h0000_0007, 5'h0F, 0, 0, resp, lat);
    chk("irq_set", {31'd0, irq[0]}, 32'd1);
    do_write(0, 8'h00, 32'h8000_0001, 5'h0F, 0, 0, resp, lat);
    chk("irq_clear", {31'd0, irq[0]}, 32'd0);
    do_read(0, 8'h00, 0, rd, resp, lat);
    chk("irq_ctrl_readback", rd, 32'h0000_0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
